// File: rtl/ddr_owner_ctl.sv
// ddr_owner_ctl: hands the single DDR AXI4 port between the host PCIS DMA
// path and the StreamingWrapper kernel, draining in-flight traffic at each
// handover and holding the kernel in reset for a fixed window.
//
// Ports:
//   clk, pipe_rst_n          core clock, asynchronous active-low reset
//   start_req                OCL request to hand the port to the kernel
//   kern_finished            StreamingWrapper finished flag
//   ddr_aw*/w*/b*/ar*/r*     monitored handshakes on the DDR side of the mux
//   kern_sel                 mux select, 1 routes DDR to the kernel
//   addr_gate                blocks new AW/AR issue on the mux
//   kern_reset               synchronous reset to the StreamingWrapper
//   done_pulse               one-cycle completion strobe to the OCL slave
//   state                    current state encoding
//   wr_outst, rd_outst       outstanding write / read bursts
//   err                      sticky counter underflow / overflow flag
module ddr_owner_ctl #(
    parameter int RST_CYCLES = 32,
    parameter int OUTST_W    = 8
) (
    input  logic               clk,
    input  logic               pipe_rst_n,
    input  logic               start_req,
    input  logic               kern_finished,
    input  logic               ddr_awvalid,
    input  logic               ddr_awready,
    input  logic               ddr_wvalid,
    input  logic               ddr_wready,
    input  logic               ddr_wlast,
    input  logic               ddr_bvalid,
    input  logic               ddr_bready,
    input  logic               ddr_arvalid,
    input  logic               ddr_arready,
    input  logic               ddr_rvalid,
    input  logic               ddr_rready,
    input  logic               ddr_rlast,
    output logic               kern_sel,
    output logic               addr_gate,
    output logic               kern_reset,
    output logic               done_pulse,
    output logic [2:0]         state,
    output logic [OUTST_W-1:0] wr_outst,
    output logic [OUTST_W-1:0] rd_outst,
    output logic               err
);
    typedef enum logic [2:0] {
        HOST    = 3'd0,
        DRAIN_H = 3'd1,
        KRST    = 3'd2,
        KERN    = 3'd3,
        DRAIN_K = 3'd4
    } st_t;

    localparam logic [OUTST_W-1:0] CMAX     = '1;
    localparam logic [OUTST_W-1:0] ONE      = 1;
    localparam logic [OUTST_W:0]   BONE     = 1;
    localparam logic [OUTST_W:0]   BMAX     = {1'b0, {OUTST_W{1'b1}}};
    localparam logic [OUTST_W:0]   BMIN     = {1'b1, {OUTST_W{1'b0}}};
    localparam logic [7:0]         RST_LAST = 8'(RST_CYCLES - 1);

    st_t cur, nxt;
    logic [7:0] rst_cnt;
    logic aw_hs, w_hs, w_last_hs, b_hs, ar_hs, r_last_hs, idle;
    logic [OUTST_W:0]   w_bal, bal_nxt;
    logic [OUTST_W-1:0] wr_nxt, rd_nxt;
    logic cnt_err;
    logic sel_d, gate_d, krst_d, done_d;

    assign aw_hs     = ddr_awvalid && ddr_awready;
    assign w_hs      = ddr_wvalid && ddr_wready;
    assign w_last_hs = w_hs && ddr_wlast;
    assign b_hs      = ddr_bvalid && ddr_bready;
    assign ar_hs     = ddr_arvalid && ddr_arready;
    assign r_last_hs = ddr_rvalid && ddr_rready && ddr_rlast;

    // A handshake in the current cycle is not yet reflected in the counters,
    // so it must also veto idle.
    assign idle = (wr_outst == '0) && (rd_outst == '0) && (w_bal == '0)
                  && !aw_hs && !ar_hs && !w_hs;

    // Saturating up/down counters; simultaneous inc and dec cancel.
    // w_bal is two's complement: W data may legally precede its AW.
    always_comb begin
        wr_nxt  = wr_outst;
        rd_nxt  = rd_outst;
        bal_nxt = w_bal;
        cnt_err = 1'b0;
        if (aw_hs && !b_hs) begin
            if (wr_outst == CMAX) cnt_err = 1'b1;
            else                  wr_nxt  = wr_outst + ONE;
        end else if (b_hs && !aw_hs) begin
            if (wr_outst == '0) cnt_err = 1'b1;
            else                wr_nxt  = wr_outst - ONE;
        end
        if (ar_hs && !r_last_hs) begin
            if (rd_outst == CMAX) cnt_err = 1'b1;
            else                  rd_nxt  = rd_outst + ONE;
        end else if (r_last_hs && !ar_hs) begin
            if (rd_outst == '0) cnt_err = 1'b1;
            else                rd_nxt  = rd_outst - ONE;
        end
        if (aw_hs && !w_last_hs) begin
            if (w_bal == BMAX) cnt_err = 1'b1;
            else               bal_nxt = w_bal + BONE;
        end else if (w_last_hs && !aw_hs) begin
            if (w_bal == BMIN) cnt_err = 1'b1;
            else               bal_nxt = w_bal - BONE;
        end
    end

    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            wr_outst <= '0;
            rd_outst <= '0;
            w_bal    <= '0;
            err      <= 1'b0;
        end else begin
            wr_outst <= wr_nxt;
            rd_outst <= rd_nxt;
            w_bal    <= bal_nxt;
            err      <= err | cnt_err;
        end
    end

    // State register; outputs are registered from the next state so they
    // always describe the state currently held.
    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            cur        <= HOST;
            rst_cnt    <= '0;
            kern_sel   <= 1'b0;
            addr_gate  <= 1'b0;
            kern_reset <= 1'b1;
            done_pulse <= 1'b0;
        end else begin
            cur        <= nxt;
            rst_cnt    <= (cur == KRST) ? rst_cnt + 8'd1 : '0;
            kern_sel   <= sel_d;
            addr_gate  <= gate_d;
            kern_reset <= krst_d;
            done_pulse <= done_d;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            HOST:    nxt = start_req ? DRAIN_H : HOST;
            DRAIN_H: nxt = idle ? KRST : DRAIN_H;
            KRST:    nxt = (rst_cnt == RST_LAST) ? KERN : KRST;
            KERN:    nxt = kern_finished ? DRAIN_K : KERN;
            DRAIN_K: nxt = idle ? HOST : DRAIN_K;
            default: nxt = HOST;
        endcase
    end

    always_comb begin
        sel_d  = (nxt == KRST) || (nxt == KERN) || (nxt == DRAIN_K);
        gate_d = (nxt == DRAIN_H) || (nxt == KRST) || (nxt == DRAIN_K);
        krst_d = (nxt == HOST) || (nxt == DRAIN_H) || (nxt == KRST);
        done_d = (cur == DRAIN_K) && (nxt == HOST);
    end

    assign state = cur;
endmodule

// File: tb/tb_ddr_owner_ctl.sv
// tb_ddr_owner_ctl: directed scoreboard bench for ddr_owner_ctl.
module tb_ddr_owner_ctl;
  logic clk, pipe_rst_n, start_req, kern_finished;
  logic ddr_awvalid, ddr_awready, ddr_wvalid, ddr_wready, ddr_wlast;
  logic ddr_bvalid, ddr_bready, ddr_arvalid, ddr_arready;
  logic ddr_rvalid, ddr_rready, ddr_rlast;
  logic kern_sel, addr_gate, kern_reset, done_pulse, err;
  logic [2:0] state;
  logic [7:0] wr_outst, rd_outst;
  logic finished;
  ddr_owner_ctl #(.RST_CYCLES(32), .OUTST_W(8)) dut (
    .clk(clk), .pipe_rst_n(pipe_rst_n), .start_req(start_req),
    .kern_finished(kern_finished),
    .ddr_awvalid(ddr_awvalid), .ddr_awready(ddr_awready),
    .ddr_wvalid(ddr_wvalid), .ddr_wready(ddr_wready), .ddr_wlast(ddr_wlast),
    .ddr_bvalid(ddr_bvalid), .ddr_bready(ddr_bready),
    .ddr_arvalid(ddr_arvalid), .ddr_arready(ddr_arready),
    .ddr_rvalid(ddr_rvalid), .ddr_rready(ddr_rready), .ddr_rlast(ddr_rlast),
    .kern_sel(kern_sel), .addr_gate(addr_gate), .kern_reset(kern_reset),
    .done_pulse(done_pulse), .state(state),
    .wr_outst(wr_outst), .rd_outst(rd_outst), .err(err)
  );
  localparam int S  = 'h001;
  localparam int F  = 'h002;
  localparam int AW = 'h004;
  localparam int WL = 'h018;
  localparam int B  = 'h020;
  localparam int AR = 'h040;
  localparam int R  = 'h080;
  localparam int RL = 'h180;
  localparam int BV = 'h200;
  typedef struct {
    string       n;
    logic [23:0] v;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int chk_cnt = 0;
  int pass_cnt = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic push(input string n, input logic [2:0] st, input logic [7:0] wr,
                      input logic [7:0] rd, input logic er, input logic d);
    exp_t x;
    logic sel, gate, krst;
    sel  = (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
    gate = (st == 3'd1) || (st == 3'd2) || (st == 3'd4);
    krst = (st == 3'd0) || (st == 3'd1) || (st == 3'd2);
    x.n = n;
    x.v = {st, sel, gate, krst, d, er, wr, rd};
    q.push_back(x);
  endtask
  task automatic step(input int v);
    start_req     = v[0];
    kern_finished = v[1];
    ddr_awvalid   = v[2];
    ddr_awready   = v[2];
    ddr_wvalid    = v[3];
    ddr_wready    = v[3];
    ddr_wlast     = v[4];
    ddr_bvalid    = v[5] | v[9];
    ddr_bready    = v[5];
    ddr_arvalid   = v[6];
    ddr_arready   = v[6];
    ddr_rvalid    = v[7];
    ddr_rready    = v[7];
    ddr_rlast     = v[8];
    @(posedge clk);
    #1;
    {start_req, kern_finished, ddr_awvalid, ddr_awready, ddr_wvalid, ddr_wready,
     ddr_wlast, ddr_bvalid, ddr_bready, ddr_arvalid, ddr_arready,
     ddr_rvalid, ddr_rready, ddr_rlast} = '0;
  endtask
  always @(negedge clk) begin
    while (q.size() != 0) begin
      e = q.pop_front();
      chk_cnt++;
      if ({state, kern_sel, addr_gate, kern_reset, done_pulse, err, wr_outst, rd_outst} === e.v)
        pass_cnt++;
      else
        $display("FAIL %s: got st=%0d sel=%b gate=%b krst=%b done=%b err=%b wr=%0d rd=%0d, want st=%0d sel=%b gate=%b krst=%b done=%b err=%b wr=%0d rd=%0d",
                 e.n, state, kern_sel, addr_gate, kern_reset, done_pulse, err, wr_outst, rd_outst,
                 e.v[23:21], e.v[20], e.v[19], e.v[18], e.v[17], e.v[16], e.v[15:8], e.v[7:0]);
    end
  end
  initial begin
    finished = 1'b0;
    #20000;
    if (!finished) begin
      $display("FAIL timeout: bench did not complete");
      $finish;
    end
  end
  initial begin
    pipe_rst_n = 1'b0;
    {start_req, kern_finished, ddr_awvalid, ddr_awready, ddr_wvalid, ddr_wready,
     ddr_wlast, ddr_bvalid, ddr_bready, ddr_arvalid, ddr_arready,
     ddr_rvalid, ddr_rready, ddr_rlast} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if ({state, kern_sel, addr_gate, kern_reset, done_pulse, err, wr_outst, rd_outst} === {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0})
      pass_cnt++;
    else
      $display("FAIL reset_direct: st=%0d sel=%b gate=%b krst=%b done=%b err=%b wr=%0d rd=%0d",
               state, kern_sel, addr_gate, kern_reset, done_pulse, err, wr_outst, rd_outst);
    push("reset", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    pipe_rst_n = 1'b1;
    step(S);
    push("t1_drain_h", 1, 0, 0, 0, 0);
    step(0);
    push("t1_krst_first", 2, 0, 0, 0, 0);
    for (int i = 1; i < 32; i++) step(i == 5 ? S : i == 6 ? F : 0);
    push("t1_krst_last", 2, 0, 0, 0, 0);
    step(0);
    push("t1_kern", 3, 0, 0, 0, 0);
    repeat (4) step(AW | WL);
    push("t4_four_aw", 3, 4, 0, 0, 0);
    repeat (3) step(B);
    step(F);
    push("t4_drain_k", 4, 1, 0, 0, 0);
    step(0);
    push("t4_drain_k_wait", 4, 1, 0, 0, 0);
    step(B);
    push("t4_last_b", 4, 0, 0, 0, 0);
    step(0);
    push("t4_done", 0, 0, 0, 0, 1);
    step(0);
    push("t4_done_once", 0, 0, 0, 0, 0);
    repeat (3) step(AW);
    repeat (2) step(AR);
    step(S);
    push("t2_drain_start", 1, 3, 2, 0, 0);
    step(WL | B);
    push("t2_first_b", 1, 2, 2, 0, 0);
    step(WL | B | R);
    step(RL);
    push("t2_mid", 1, 1, 1, 0, 0);
    step(WL | B | RL);
    push("t2_last_resp", 1, 0, 0, 0, 0);
    step(0);
    push("t2_krst", 2, 0, 0, 0, 0);
    repeat (32) step(0);
    push("t2_kern", 3, 0, 0, 0, 0);
    step(F);
    step(0);
    push("t2_done", 0, 0, 0, 0, 1);
    step(S);
    push("t2_done_restart", 1, 0, 0, 0, 0);
    step(0);
    repeat (32) step(0);
    step(F);
    step(0);
    step(0);
    push("t2_back_host", 0, 0, 0, 0, 0);
    repeat (2) step(AW | WL);
    push("t5_two", 0, 2, 0, 0, 0);
    step(AW | WL | B);
    push("t5_same_cycle", 0, 2, 0, 0, 0);
    step(BV);
    push("t5_bvalid_only", 0, 2, 0, 0, 0);
    repeat (2) step(B);
    push("t5_zero", 0, 0, 0, 0, 0);
    step(B);
    push("t5_underflow", 0, 0, 0, 1, 0);
    step(0);
    push("t5_err_sticky", 0, 0, 0, 1, 0);
    step(S | WL);
    push("t3_w_first", 1, 0, 0, 1, 0);
    step(0);
    push("t3_wbal_blocks", 1, 0, 0, 1, 0);
    step(AW);
    push("t3_aw", 1, 1, 0, 1, 0);
    step(B);
    push("t3_b", 1, 0, 0, 1, 0);
    step(0);
    push("t3_krst", 2, 0, 0, 1, 0);
    repeat (10) step(0);
    pipe_rst_n = 1'b0;
    #1;
    push("t6_async_rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    pipe_rst_n = 1'b1;
    step(S);
    step(0);
    repeat (31) step(0);
    push("t6_krst_full", 2, 0, 0, 0, 0);
    step(0);
    push("t6_kern", 3, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    finished = 1'b1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
